// File: rtl/wave_gen.sv
// DDS-style waveform generator: phase accumulator, shape/scale/offset pipeline, shadowed config.
// Define WAVE_GEN_DITHER_EN to add a 16-bit LFSR dither to the scaled sample.
module wave_gen #(
  parameter int unsigned DAC_BITS   = 14,
  parameter int unsigned PHASE_BITS = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  val_req,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [1:0]            cfg_wave,
  input  logic [PHASE_BITS-1:0] cfg_step,
  input  logic [DAC_BITS-1:0]   cfg_amp,
  input  logic [DAC_BITS-1:0]   cfg_offset,
  output logic [DAC_BITS-1:0]   dac_val,
  output logic                  wrap
);

  typedef struct packed {
    logic [1:0]            wave;
    logic [PHASE_BITS-1:0] step;
    logic [DAC_BITS-1:0]   amp;
    logic [DAC_BITS-1:0]   offset;
  } cfg_t;

  localparam cfg_t CfgRst = '{wave: 2'd0, step: '0, amp: '1, offset: '0};

  cfg_t                  active_q, active_d, shadow_q, shadow_d, cfg_in;
  logic                  pending_q, pending_d;
  logic [PHASE_BITS-1:0] phase_q, phase_d, phase_sum;
  logic                  carry, launch, transfer;
  logic                  wrap_q, wrap_d;
  logic [DAC_BITS-1:0]   p, tri_v, shape;
  logic [1:0]            dith;

  logic                  s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic [DAC_BITS-1:0]   s1_shape_q, s1_shape_d, s1_amp_q, s1_amp_d, s1_off_q, s1_off_d;
  logic [DAC_BITS-1:0]   s2_off_q, s2_off_d;
  logic [DAC_BITS:0]     s2_sc_q, s2_sc_d, amp_p1;
  logic [2*DAC_BITS-1:0] prod;
  logic [DAC_BITS+1:0]   sum;
  logic [DAC_BITS-1:0]   dac_q, dac_d;

  assign cfg_in    = '{wave: cfg_wave, step: cfg_step, amp: cfg_amp, offset: cfg_offset};
  assign launch    = val_req & enable;
  assign cfg_ready = ~pending_q;
  assign transfer  = cfg_valid & cfg_ready;
  assign dac_val   = dac_q;
  assign wrap      = wrap_q;

  always_comb begin
    {carry, phase_sum} = {1'b0, phase_q} + {1'b0, active_q.step};
    phase_d   = launch ? phase_sum : phase_q;
    wrap_d    = launch & carry;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    // A pending config lands on a carry-out launch, or at once if the generator is stopped.
    if (pending_q && (!enable || (launch && carry))) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (transfer) begin
      shadow_d = cfg_in;
      if (enable) pending_d = 1'b1;
      else        active_d  = cfg_in;
    end
  end

  always_comb begin
    p     = phase_q[PHASE_BITS-1 -: DAC_BITS];
    tri_v = {p[DAC_BITS-2:0], 1'b0};
    shape = p;
    case (active_q.wave)
      2'd0:    shape = p;
      2'd1:    shape = ~p;
      2'd2:    shape = p[DAC_BITS-1] ? ~tri_v : tri_v;
      default: shape = {DAC_BITS{p[DAC_BITS-1]}};
    endcase
  end

  always_comb begin
    s1_vld_d   = launch;
    s1_shape_d = shape;
    s1_amp_d   = active_q.amp;
    s1_off_d   = active_q.offset;
    amp_p1     = {1'b0, s1_amp_q} + {{DAC_BITS{1'b0}}, 1'b1};
    // Product always fits 2*DAC_BITS since shape < 2^DAC_BITS and amp+1 <= 2^DAC_BITS.
    prod       = {{DAC_BITS{1'b0}}, s1_shape_q} * {{(DAC_BITS-1){1'b0}}, amp_p1};
    s2_vld_d   = s1_vld_q;
    s2_sc_d    = (DAC_BITS+1)'((prod >> DAC_BITS) + {{(2*DAC_BITS-2){1'b0}}, dith});
    s2_off_d   = s1_off_q;
    sum        = {2'b00, s2_off_q} + {1'b0, s2_sc_q};
    dac_d      = dac_q;
    if (s2_vld_q) dac_d = (|sum[DAC_BITS+1:DAC_BITS]) ? '1 : sum[DAC_BITS-1:0];
  end

`ifdef WAVE_GEN_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [1:0]  s1_dith_q, s1_dith_d;

  always_comb begin
    lfsr_d    = lfsr_q;
    s1_dith_d = lfsr_q[1:0];
    if (launch) lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q    <= 16'hACE1;
      s1_dith_q <= 2'b00;
    end else begin
      lfsr_q    <= lfsr_d;
      s1_dith_q <= s1_dith_d;
    end
  end

  assign dith = s1_dith_q;
`else
  assign dith = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      active_q   <= CfgRst;
      shadow_q   <= CfgRst;
      pending_q  <= 1'b0;
      wrap_q     <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_shape_q <= '0;
      s1_amp_q   <= '0;
      s1_off_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_sc_q    <= '0;
      s2_off_q   <= '0;
      dac_q      <= '0;
    end else begin
      phase_q    <= phase_d;
      active_q   <= active_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      wrap_q     <= wrap_d;
      s1_vld_q   <= s1_vld_d;
      s1_shape_q <= s1_shape_d;
      s1_amp_q   <= s1_amp_d;
      s1_off_q   <= s1_off_d;
      s2_vld_q   <= s2_vld_d;
      s2_sc_q    <= s2_sc_d;
      s2_off_q   <= s2_off_d;
      dac_q      <= dac_d;
    end
  end

endmodule
